// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Turns one raw, asynchronous board button into clean synchronous signals.
// The raw pad level goes through a polarity fix-up, a two-flop synchroniser
// and a counter-based debouncer. Registered one-cycle pulses then mark press,
// release and a one-shot long press.
//
// Parameters:
//   DEBOUNCE_CYCLES   - cycles the synchronised level must disagree with the
//                       debounced state before that state flips (>= 1)
//   LONG_PRESS_CYCLES - cycles after pressed rises at which long_press fires (>= 1)
//   ACTIVE_LOW        - 1: raw low means pressed; 0: raw high means pressed
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   btn_raw       in   asynchronous pad level
//   pressed       out  debounced level, 1 = pressed
//   press         out  one-cycle pulse after pressed goes 0->1
//   release_pulse out  one-cycle pulse after pressed goes 1->0
//                      (`release` is a reserved word in SystemVerilog)
//   long_press    out  one-cycle pulse, at most once per press
//
// Every output is driven directly by a flop. There is no combinational path
// from btn_raw to any output.
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 120000,
    parameter int LONG_PRESS_CYCLES = 12000000,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic pressed,
    output logic press,
    output logic release_pulse,
    output logic long_press
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    logic          btn_in;
    logic          sync1;
    logic          sync2;
    logic [DW-1:0] deb_cnt;
    logic          pressed_d;
    logic [HW-1:0] hold_cnt;

    // Normalise polarity so that 1 always means pressed ahead of the synchroniser.
    assign btn_in = btn_raw ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            deb_cnt       <= '0;
            pressed       <= 1'b0;
            pressed_d     <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            hold_cnt      <= '0;
            long_press    <= 1'b0;
        end else begin
            // Synchroniser stage
            sync1 <= btn_in;
            sync2 <= sync1;

            // Debounce stage: a single cycle of agreement with the current
            // state restarts the count, which rejects bounce.
            if (sync2 == pressed) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                pressed <= ~pressed;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end

            // Edge-pulse stage
            pressed_d     <= pressed;
            press         <= pressed & ~pressed_d;
            release_pulse <= ~pressed & pressed_d;

            // Long-press stage: hold_cnt saturates at the threshold, so the
            // pulse cannot fire again until a release and a fresh press.
            if (!pressed) begin
                hold_cnt   <= '0;
                long_press <= 1'b0;
            end else if (hold_cnt < HOLD_MAX) begin
                hold_cnt   <= hold_cnt + HW'(1);
                long_press <= (hold_cnt == HOLD_LAST);
            end else begin
                long_press <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
`timescale 1ns/1ps
module tb_button_conditioner;

    localparam int DEB  = 4;
    localparam int LONG = 10;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic btn_raw = 1'b1;
    logic pressed;
    logic press;
    logic release_pulse;
    logic long_press;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    ev_t sb[$];

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_PRESS_CYCLES(LONG),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .pressed(pressed),
        .press(press),
        .release_pulse(release_pulse),
        .long_press(long_press)
    );

    always #80 clk = ~clk;

    // cyc = number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input int kind, input string tag);
        ev_t e;
        if (sb.size() == 0) begin
            chk_int({tag, "_unexpected_at_cycle"}, cyc, -1);
        end else begin
            e = sb.pop_front();
            chk_int({tag, "_kind"}, kind, e.kind);
            chk_int({tag, "_cycle"}, cyc, e.at);
        end
    endtask

    // Pulse monitor: every pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (press && release_pulse)
            chk_bit("press_and_release_together", 1'b1, 1'b0);
        if (press)         expect_pulse(K_PRESS, "press");
        if (release_pulse) expect_pulse(K_REL, "release");
        if (long_press)    expect_pulse(K_LONG, "long_press");
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        sb.push_back(e);
    endtask

    initial begin
        #(160 * 5000);
        $display("FAIL watchdog_timeout cycle=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int r;
        int p;

        // 1. Reset and polarity
        reset   = 1'b1;
        btn_raw = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_bit("rst_pressed", pressed, 1'b0);
            chk_bit("rst_press", press, 1'b0);
            chk_bit("rst_release", release_pulse, 1'b0);
            chk_bit("rst_long", long_press, 1'b0);
        end
        reset = 1'b0;
        repeat (50) @(negedge clk);
        chk_bit("idle_pressed", pressed, 1'b0);
        chk_int("idle_events_pending", sb.size(), 0);

        // 2. Clean press then release before the long-press threshold
        k = cyc + 1;
        btn_raw = 1'b0;
        push(K_PRESS, k + 6);
        wait_until(k + 4);
        chk_bit("clean_pressed_before", pressed, 1'b0);
        wait_until(k + 5);
        chk_bit("clean_pressed_rise", pressed, 1'b1);
        wait_until(k + 7);
        btn_raw = 1'b1;
        r = cyc + 1;
        push(K_REL, r + 6);
        wait_until(r + 4);
        chk_bit("clean_pressed_hold", pressed, 1'b1);
        wait_until(r + 5);
        chk_bit("clean_pressed_fall", pressed, 1'b0);
        wait_until(r + 8);
        chk_int("clean_events_pending", sb.size(), 0);

        // 3. Bounce rejection
        for (int i = 0; i < 10; i++) begin
            btn_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) begin
                @(negedge clk);
                chk_bit("bounce_pressed", pressed, 1'b0);
            end
        end
        k = cyc + 1;
        btn_raw = 1'b0;
        push(K_PRESS, k + 6);
        wait_until(k + 4);
        chk_bit("bounce_settle_before", pressed, 1'b0);
        wait_until(k + 5);
        chk_bit("bounce_settle_rise", pressed, 1'b1);
        btn_raw = 1'b1;
        r = cyc + 1;
        push(K_REL, r + 6);
        wait_until(r + 8);
        chk_bit("bounce_released", pressed, 1'b0);
        chk_int("bounce_events_pending", sb.size(), 0);

        // 4. Long press: exactly one long_press pulse
        k = cyc + 1;
        btn_raw = 1'b0;
        push(K_PRESS, k + 6);
        push(K_LONG, k + 15);
        wait_until(k + 5);
        chk_bit("long_pressed_rise", pressed, 1'b1);
        wait_until(k + 30);
        chk_bit("long_still_pressed", pressed, 1'b1);
        btn_raw = 1'b1;
        r = cyc + 1;
        push(K_REL, r + 6);
        wait_until(r + 5);
        chk_bit("long_pressed_fall", pressed, 1'b0);
        wait_until(r + 8);
        chk_int("long_events_pending", sb.size(), 0);

        // 5. Short press: six cycles of pressed=1, no long_press
        k = cyc + 1;
        btn_raw = 1'b0;
        push(K_PRESS, k + 6);
        wait_until(k + 5);
        chk_bit("short_pressed_rise", pressed, 1'b1);
        btn_raw = 1'b1;
        r = cyc + 1;
        push(K_REL, r + 6);
        wait_until(r + 4);
        chk_bit("short_pressed_last", pressed, 1'b1);
        wait_until(r + 5);
        chk_bit("short_pressed_fall", pressed, 1'b0);
        wait_until(r + 20);
        chk_int("short_events_pending", sb.size(), 0);

        // 6. Reset mid-press with the button held
        k = cyc + 1;
        btn_raw = 1'b0;
        push(K_PRESS, k + 6);
        p = k + 5;
        wait_until(p);
        chk_bit("midrst_pressed_rise", pressed, 1'b1);
        wait_until(p + 5);
        reset = 1'b1;
        wait_until(p + 6);
        chk_bit("midrst_pressed_cleared", pressed, 1'b0);
        chk_bit("midrst_no_release", release_pulse, 1'b0);
        reset = 1'b0;
        k = cyc + 1;
        push(K_PRESS, k + 6);
        push(K_LONG, k + 15);
        wait_until(k + 1);
        chk_bit("midrst_no_release_after", release_pulse, 1'b0);
        wait_until(k + 4);
        chk_bit("midrst_repress_before", pressed, 1'b0);
        wait_until(k + 5);
        chk_bit("midrst_repress_rise", pressed, 1'b1);
        wait_until(k + 16);
        btn_raw = 1'b1;
        r = cyc + 1;
        push(K_REL, r + 6);
        wait_until(r + 8);
        chk_bit("midrst_final_released", pressed, 1'b0);
        chk_int("midrst_events_pending", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
